matmul_seq: RTL and testbench

- Sequences a 3x3 by 3x3 unsigned 8-bit matrix multiply through one shared multiply-accumulate unit.
- Internal register banks hold matrix A and matrix B, loaded over a simple write port.
- On start, computes each C[i][j] = sum over k of A[i][k]*B[k][j] one term per cycle, with a 16-bit wrapping accumulator.
- Streams the 9 results row-major over a valid/ready port, then pulses done.

---
 rtl/matmul_seq.sv | 106 ++++++++++
 tb/tb_matmul_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// matmul_seq: NxN unsigned matrix multiply sequenced through one shared MAC, results streamed row-major.
module matmul_seq #(
  parameter int DW = 8,
  parameter int N  = 3,
  parameter int AW = 2 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [3:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_data,
  output logic [3:0]    res_idx,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, MAC, OUT, FIN} state_t;
  state_t          state_q;
  logic [DW-1:0]   a_q [N*N];
  logic [DW-1:0]   b_q [N*N];
  logic [1:0]      i_q, j_q, k_q;
  logic [AW-1:0]   acc_q;
  logic            busy_q, valid_q, done_q;
  logic [3:0]      idx_q;
  logic [3:0]      a_addr, b_addr;
  logic [2*DW-1:0] prod;
  logic            last_k, last_j, last_e;
  always_comb begin
    a_addr = 4'(i_q * N + k_q);
    b_addr = 4'(k_q * N + j_q);
    prod   = a_q[a_addr] * b_q[b_addr];
    last_k = k_q == 2'(N - 1);
    last_j = j_q == 2'(N - 1);
    last_e = last_j && i_q == 2'(N - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_en && int'(ld_addr) < N * N) begin
            if (ld_sel) b_q[ld_addr] <= ld_data;
            else        a_q[ld_addr] <= ld_data;
          end
          if (start) begin
            state_q <= MAC;
            busy_q  <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_q + AW'(prod);
          k_q   <= last_k ? 2'd0 : k_q + 2'd1;
          if (last_k) begin
            state_q <= OUT;
            valid_q <= 1'b1;
            idx_q   <= 4'(i_q * N + j_q);
          end
        end
        OUT: begin
          // Everything holds until the consumer takes the result.
          if (res_ready) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            if (last_e) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= MAC;
              j_q     <= last_j ? 2'd0 : j_q + 2'd1;
              i_q     <= last_j ? i_q + 2'd1 : i_q;
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_data  = acc_q;
  assign res_idx   = idx_q;
  assign done      = done_q;
endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: randomized self-checking bench for matmul_seq against a plain-arithmetic matrix model.
module tb_matmul_seq;
  localparam int N = 3;
  logic        clk = 0;
  logic        rst = 1;
  logic        ld_en = 0, ld_sel = 0;
  logic [3:0]  ld_addr = 0;
  logic [7:0]  ld_data = 0;
  logic        start = 0;
  logic        busy, res_valid, done;
  logic        res_ready = 0;
  logic [15:0] res_data;
  logic [3:0]  res_idx;
  int n_cmp = 0, n_err = 0;
  int ea [9];
  int eb [9];

  matmul_seq dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_c(input int idx);
    int s = 0;
    for (int k = 0; k < N; k++) s += ea[(idx / N) * N + k] * eb[k * N + idx % N];
    return s % 65536;
  endfunction

  task automatic load(input bit sel, input int addr, input int data);
    ld_en = 1; ld_sel = sel; ld_addr = 4'(addr); ld_data = 8'(data);
    tick();
    ld_en = 0;
  endtask

  task automatic push_banks();
    for (int e = 0; e < 9; e++) begin
      load(0, e, ea[e]);
      load(1, e, eb[e]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_data"}, res_data, 0);
    check({tag, "_idx"}, res_idx, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode 0: ready always high; mode 1: random ready with 5-cycle stalls
  task automatic run(input int mode, input bit disturb, output int first_v, output int done_c);
    int got = 0, c, ndone = 0, stall = 0;
    logic pv = 0;
    logic [15:0] pd = 0;
    logic [3:0] pi = 0;
    first_v = -1;
    done_c = -1;
    start = 1;
    tick();
    start = 0;
    ld_en = 0;
    c = 1;
    check("busy_rise", busy, 1);
    while (c < 600) begin
      start = 0;
      ld_en = 0;
      if (pv) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, pd);
        check("hold_idx", res_idx, pi);
      end
      if (res_valid && first_v < 0) first_v = c;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
        check("busy_in_fin", busy, 0);
      end else if (done_c >= 0) begin
        check("busy_after", busy, 0);
        check("valid_after", res_valid, 0);
        if (c > done_c + 3) break;
      end
      if (mode == 0) res_ready = 1;
      else if (stall > 0) begin res_ready = 0; stall--; end
      else if ($urandom_range(0, 3) == 0) begin res_ready = 0; stall = 4; end
      else res_ready = 1;
      if (res_valid && res_ready) begin
        check("res_idx", res_idx, got);
        check("res_data", res_data, exp_c(got));
        got++;
      end
      pv = res_valid && !res_ready;
      pd = res_data;
      pi = res_idx;
      if (disturb && busy) begin
        start = 1'($urandom_range(0, 1));
        ld_en = 1'($urandom_range(0, 1));
        ld_sel = 1'($urandom_range(0, 1));
        ld_addr = 4'($urandom_range(0, 8));
        ld_data = 8'($urandom_range(1, 255));
      end
      tick();
      c++;
    end
    start = 0;
    ld_en = 0;
    check("finished", done_c >= 0, 1);
    check("result_count", got, N * N);
    check("done_count", ndone, 1);
  endtask

  initial begin
    int fv, dc, hs;
    tick(); tick(); tick();
    check_zero_outputs("reset");
    rst = 0;

    // identity times 1..9, with exact latency
    for (int e = 0; e < 9; e++) begin ea[e] = (e / 3 == e % 3) ? 1 : 0; eb[e] = e + 1; end
    push_banks();
    run(0, 0, fv, dc);
    check("first_valid_lat", fv, 4);
    check("done_lat", dc, 37);

    // wrapping accumulation
    for (int e = 0; e < 9; e++) begin ea[e] = 255; eb[e] = 255; end
    push_banks();
    run(0, 0, fv, dc);
    check("wrap_const", exp_c(4), 64003);

    // backpressure on A=B={1..9}
    for (int e = 0; e < 9; e++) begin ea[e] = e + 1; eb[e] = e + 1; end
    push_banks();
    run(1, 0, fv, dc);

    // disturbed run, then an undisturbed run on the same banks
    run(1, 1, fv, dc);
    run(0, 0, fv, dc);

    // random matrices; last B write coincides with start
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 9; e++) begin ea[e] = $urandom_range(0, 255); eb[e] = $urandom_range(0, 255); end
      push_banks();
      eb[8] = $urandom_range(0, 255);
      ld_en = 1; ld_sel = 1; ld_addr = 4'd8; ld_data = 8'(eb[8]);
      run(r % 2, 0, fv, dc);
    end

    // reset during the 4th element's MAC
    hs = 0;
    res_ready = 1;
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 200 && hs < 3; c++) begin
      if (res_valid) hs++;
      tick();
    end
    check("hs_before_rst", hs, 3);
    tick();
    rst = 1;
    tick();
    rst = 0;
    check_zero_outputs("midrun_rst");
    for (int e = 0; e < 9; e++) begin ea[e] = 0; eb[e] = 0; end
    run(0, 0, fv, dc);

    // out-of-range writes must not disturb the banks
    for (int e = 0; e < 9; e++) begin ea[e] = (e / 3 == e % 3) ? 1 : 0; eb[e] = e + 1; end
    push_banks();
    for (int a = 9; a < 16; a++) begin
      load(0, a, $urandom_range(1, 255));
      load(1, a, $urandom_range(1, 255));
    end
    run(0, 0, fv, dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
